mem_arbiter: RTL

Sequential arbiter that shares the single-ported unified memory between the fetch stage (instruction reads) and the memory stage (LD/ST/STU data accesses) of the WISC processor. It issues one access at a time to a stalling memory, tracks the memory's stall/done handshake, and returns data and completion pulses to the winning requester. It holds the losing requester stalled and guarantees fetch forward progress with a starvation counter. It sits between the fetch/memory stages and the memory macro, and its stall outputs feed the pipeline hazard logic.

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Sequential arbiter sharing one single-ported stalling memory between fetch and data accesses.
// One access in flight at a time; fetch forward progress is guaranteed by a starvation counter.
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              m_stall,
    input  logic              m_done,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              m_en,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              if_valid,
    output logic              mem_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic              owner, owner_nx;      // 1: data port owns the access
    logic [SW-1:0]     starve_cnt, starve_nx;
    logic [TW-1:0]     tmo_cnt, tmo_nx;
    logic              en_nx, wr_nx, if_v_nx, mem_v_nx, err_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wdata_nx, if_rd_nx, mem_rd_nx, fin_data;
    logic              finish, data_req;

    assign data_req  = mem_rd | mem_wr;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = data_req & ~mem_valid;

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        starve_nx = starve_cnt;
        tmo_nx    = tmo_cnt;
        en_nx     = 1'b0;
        wr_nx     = m_wr;
        addr_nx   = m_addr;
        wdata_nx  = m_wdata;
        if_v_nx   = 1'b0;
        mem_v_nx  = 1'b0;
        if_rd_nx  = if_rdata;
        mem_rd_nx = mem_rdata;
        err_nx    = err;
        finish    = 1'b0;
        fin_data  = '0;
        case (state)
            IDLE: begin
                tmo_nx = '0;
                if (data_req && starve_cnt != STARVE_LIM) begin
                    owner_nx = 1'b1;
                    addr_nx  = mem_addr;
                    wdata_nx = mem_wdata;
                    wr_nx    = mem_wr;     // rd+wr together is issued as a write
                    if (mem_rd && mem_wr) err_nx = 1'b1;
                    if (if_req) starve_nx = starve_cnt + 1'b1;
                    state_nx = ISSUE;
                    en_nx    = 1'b1;
                end else if (if_req) begin
                    owner_nx  = 1'b0;
                    addr_nx   = if_addr;
                    wdata_nx  = '0;
                    wr_nx     = 1'b0;
                    starve_nx = '0;
                    state_nx  = ISSUE;
                    en_nx     = 1'b1;
                end
            end
            ISSUE: begin
                tmo_nx = tmo_cnt + 1'b1;
                if (tmo_cnt == TMO_LAST) begin
                    finish = 1'b1;
                    err_nx = 1'b1;
                end else if (m_stall) begin
                    en_nx = 1'b1;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                tmo_nx = tmo_cnt + 1'b1;
                if (m_done) begin
                    finish   = 1'b1;
                    fin_data = m_rdata;
                end else if (tmo_cnt == TMO_LAST) begin
                    finish = 1'b1;
                    err_nx = 1'b1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Completion and timeout abort share the hand-off to RESP; abort returns zero data.
        if (finish) begin
            state_nx = RESP;
            if (owner) begin
                mem_v_nx  = 1'b1;
                mem_rd_nx = fin_data;
            end else begin
                if_v_nx  = 1'b1;
                if_rd_nx = fin_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            m_en       <= 1'b0;
            m_wr       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            if_valid   <= 1'b0;
            mem_valid  <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            starve_cnt <= starve_nx;
            tmo_cnt    <= tmo_nx;
            m_en       <= en_nx;
            m_wr       <= wr_nx;
            m_addr     <= addr_nx;
            m_wdata    <= wdata_nx;
            if_valid   <= if_v_nx;
            mem_valid  <= mem_v_nx;
            if_rdata   <= if_rd_nx;
            mem_rdata  <= mem_rd_nx;
            err        <= err_nx;
        end
    end

endmodule
